// File: rtl/slot_ready_ctrl.sv
// Per-slot ready conditioning: synchronizes backplane ready, enforces a configurable
// minimum wait per slot and a global timeout, and services one selected slot at a time.
module slot_ready_ctrl #(
    parameter int NUM_SLOTS = 5,
    parameter int WAIT_W    = 4,
    parameter int TMO_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] cs_n,
    input  logic [NUM_SLOTS-1:0] slot_ready_n_raw,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    input  logic                 tmo_clr,
    output logic [NUM_SLOTS-1:0] dev_ready_n,
    output logic                 tmo_flag,
    output logic [2:0]           tmo_slot
);

    localparam int CMP_W = (TMO_W > 8) ? TMO_W : 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_SLOTS-1:0]  sync1_q, sync2_q;
    logic [WAIT_W-1:0]     wait_q [NUM_SLOTS];
    logic [WAIT_W-1:0]     wait_d [NUM_SLOTS];
    logic [7:0]            tmo_lim_q, tmo_lim_d;
    logic [2:0]            sel_q, sel_d;
    logic [WAIT_W-1:0]     cur_wait_q, cur_wait_d;
    logic [7:0]            cur_lim_q, cur_lim_d;
    logic [TMO_W-1:0]      e_q, e_d;
    logic                  tmo_flag_q, tmo_flag_d;
    logic [2:0]            tmo_slot_q, tmo_slot_d;

    logic                  any_cs_s;
    logic [2:0]            sel_s;
    logic [2:0]            cur_sel_s;
    logic [WAIT_W-1:0]     cur_wait_s;
    logic [7:0]            cur_lim_s;
    logic [TMO_W-1:0]      cur_e_s;
    logic                  stretch_s;
    logic                  tmo_hit_s;
    logic                  drive_en_s;
    logic                  ready_s;
    logic                  tmo_event_s;

    // Lowest-index active select wins; scan from the top so the lowest overwrites.
    always_comb begin
        any_cs_s = 1'b0;
        sel_s    = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            sel_s    = (!cs_n[i]) ? 3'(i) : sel_s;
            any_cs_s = any_cs_s | ~cs_n[i];
        end
    end

    // In IDLE the live config and a zero elapsed count apply, so the first cycle
    // can already stretch; afterwards the values captured at cycle 0 are used.
    always_comb begin
        cur_sel_s  = (state_q == ST_IDLE) ? sel_s          : sel_q;
        cur_wait_s = (state_q == ST_IDLE) ? wait_q[sel_s]  : cur_wait_q;
        cur_lim_s  = (state_q == ST_IDLE) ? tmo_lim_q      : cur_lim_q;
        cur_e_s    = (state_q == ST_IDLE) ? {TMO_W{1'b0}}  : e_q;
        stretch_s  = (CMP_W'(cur_e_s) < CMP_W'(cur_wait_s)) || !sync2_q[cur_sel_s];
        tmo_hit_s  = (cur_lim_s != 8'd0) && (CMP_W'(cur_e_s) == CMP_W'(cur_lim_s)) && stretch_s;
    end

    // Config register decode; unknown addresses leave everything unchanged.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            wait_d[i] = (cfg_we && (cfg_addr == 8'(32 + i))) ? cfg_wdata[WAIT_W-1:0] : wait_q[i];
        end
        tmo_lim_d = (cfg_we && (cfg_addr == 8'h28)) ? cfg_wdata : tmo_lim_q;
    end

    // Slot service FSM: next state, captured transaction context and ready drive.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cur_wait_d  = cur_wait_q;
        cur_lim_d   = cur_lim_q;
        e_d         = e_q;
        drive_en_s  = 1'b0;
        ready_s     = 1'b1;
        tmo_event_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_cs_s) begin
                    sel_d       = sel_s;
                    cur_wait_d  = cur_wait_s;
                    cur_lim_d   = cur_lim_s;
                    // e is 0 during cycle 0, so the first WAIT cycle sees 1.
                    e_d         = TMO_W'(1);
                    drive_en_s  = 1'b1;
                    ready_s     = !stretch_s || tmo_hit_s;
                    tmo_event_s = tmo_hit_s;
                    state_d     = ready_s ? ST_DONE : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cs_n[sel_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    drive_en_s  = 1'b1;
                    ready_s     = !stretch_s || tmo_hit_s;
                    tmo_event_s = tmo_hit_s;
                    e_d         = (e_q == {TMO_W{1'b1}}) ? e_q : e_q + TMO_W'(1);
                    state_d     = ready_s ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                if (cs_n[sel_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    drive_en_s = 1'b1;
                    ready_s    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky timeout status; a coincident timeout beats the clear.
    always_comb begin
        tmo_flag_d = tmo_event_s ? 1'b1 : (tmo_clr ? 1'b0 : tmo_flag_q);
        tmo_slot_d = tmo_event_s ? cur_sel_s : tmo_slot_q;
    end

    // Ready output: only the serviced slot may be pulled low; reset forces all ready.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dev_ready_n[i] = (!rst && drive_en_s && (cur_sel_s == 3'(i))) ? ready_s : 1'b1;
        end
    end

    // State, config, synchronizer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= {NUM_SLOTS{1'b1}};
            sync2_q    <= {NUM_SLOTS{1'b1}};
            for (int i = 0; i < NUM_SLOTS; i++) begin
                wait_q[i] <= {WAIT_W{1'b0}};
            end
            tmo_lim_q  <= 8'h40;
            sel_q      <= 3'd0;
            cur_wait_q <= {WAIT_W{1'b0}};
            cur_lim_q  <= 8'h40;
            e_q        <= {TMO_W{1'b0}};
            tmo_flag_q <= 1'b0;
            tmo_slot_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= slot_ready_n_raw;
            sync2_q    <= sync1_q;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                wait_q[i] <= wait_d[i];
            end
            tmo_lim_q  <= tmo_lim_d;
            sel_q      <= sel_d;
            cur_wait_q <= cur_wait_d;
            cur_lim_q  <= cur_lim_d;
            e_q        <= e_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_slot_q <= tmo_slot_d;
        end
    end

    assign tmo_flag = tmo_flag_q;
    assign tmo_slot = tmo_slot_q;

endmodule

// File: tb/tb_slot_ready_ctrl.sv
// Directed bench for slot_ready_ctrl: hand-computed per-cycle expectations for
// min-wait, stall, timeout, abort, priority and reset behaviour.
module tb_slot_ready_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] cs_n;
    logic [4:0] slot_ready_n_raw;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       tmo_clr;
    logic [4:0] dev_ready_n;
    logic       tmo_flag;
    logic [2:0] tmo_slot;

    int         total;
    int         bad;
    logic [4:0] raw_v;

    slot_ready_ctrl #(.NUM_SLOTS(5), .WAIT_W(4), .TMO_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .cs_n             (cs_n),
        .slot_ready_n_raw (slot_ready_n_raw),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .tmo_clr          (tmo_clr),
        .dev_ready_n      (dev_ready_n),
        .tmo_flag         (tmo_flag),
        .tmo_slot         (tmo_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change 1ns after the edge, outputs checked 2ns later.
    task automatic cyc(input logic [4:0] cs, input logic r = 1'b0, input logic clr = 1'b0);
        @(posedge clk);
        #1;
        cs_n             = cs;
        rst              = r;
        tmo_clr          = clr;
        slot_ready_n_raw = raw_v;
        cfg_we           = 1'b0;
        #2;
    endtask

    task automatic cycw(input logic [4:0] cs, input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk);
        #1;
        cs_n             = cs;
        rst              = 1'b0;
        tmo_clr          = 1'b0;
        slot_ready_n_raw = raw_v;
        cfg_we           = 1'b1;
        cfg_addr         = addr;
        cfg_wdata        = data;
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        raw_v = 5'b11111;
        rst = 1'b1; cs_n = 5'b11111; slot_ready_n_raw = 5'b11111;
        cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = 8'h00; tmo_clr = 1'b0;

        // Reset: outputs forced ready even with selects low
        cyc(5'b11111, 1'b1);
        cyc(5'b11111, 1'b1);
        cyc(5'b00000, 1'b1);
        chk("rst_force_ready", {3'd0, dev_ready_n}, 8'h1F);
        chk("rst_flag", {7'd0, tmo_flag}, 8'h00);
        chk("rst_slot", {5'd0, tmo_slot}, 8'h00);

        // No wait: slot 1 selected, ready every cycle
        for (int k = 0; k < 4; k++) begin
            cyc(5'b11101);
            chk($sformatf("nowait_c%0d", k), {3'd0, dev_ready_n}, 8'h1F);
        end
        chk("nowait_flag", {7'd0, tmo_flag}, 8'h00);
        chk("nowait_slot", {5'd0, tmo_slot}, 8'h00);
        cyc(5'b11111);

        // Min wait of 3 on slot 2
        cycw(5'b11111, 8'h22, 8'h03);
        for (int k = 0; k < 6; k++) begin
            cyc(5'b11011);
            chk($sformatf("minwait_c%0d", k), {3'd0, dev_ready_n}, (k < 3) ? 8'h1B : 8'h1F);
        end
        raw_v = 5'b11101;
        cyc(5'b11111);
        cyc(5'b11111);

        // Device stall on slot 1, raw raised during cycle 4
        for (int k = 0; k < 8; k++) begin
            if (k == 4) raw_v = 5'b11111;
            cyc(5'b11101);
            chk($sformatf("stall_c%0d", k), {3'd0, dev_ready_n}, (k < 6) ? 8'h1D : 8'h1F);
        end
        chk("stall_noflag", {7'd0, tmo_flag}, 8'h00);

        // Timeout of 5 on stalled slot 3
        raw_v = 5'b10111;
        cycw(5'b11111, 8'h28, 8'h05);
        cyc(5'b11111);
        for (int k = 0; k < 8; k++) begin
            cyc(5'b10111);
            chk($sformatf("tmo_c%0d", k), {3'd0, dev_ready_n}, (k < 5) ? 8'h17 : 8'h1F);
            if (k == 5) chk("tmo_flag_c5", {7'd0, tmo_flag}, 8'h00);
            if (k == 6) begin
                chk("tmo_flag_c6", {7'd0, tmo_flag}, 8'h01);
                chk("tmo_slot_c6", {5'd0, tmo_slot}, 8'h03);
            end
        end
        cyc(5'b11111, 1'b0, 1'b1);
        chk("clr_cycle_flag", {7'd0, tmo_flag}, 8'h01);
        cyc(5'b11111);
        chk("clr_flag", {7'd0, tmo_flag}, 8'h00);
        chk("clr_slot_kept", {5'd0, tmo_slot}, 8'h03);

        // Abort and priority: slots 3 and 4 selected, slot 3 serviced
        cyc(5'b00111);
        chk("prio_c0", {3'd0, dev_ready_n}, 8'h17);
        cyc(5'b00111);
        chk("prio_c1", {3'd0, dev_ready_n}, 8'h17);
        cyc(5'b11111);
        chk("abort_c2", {3'd0, dev_ready_n}, 8'h1F);
        cyc(5'b11111);
        chk("abort_noflag", {7'd0, tmo_flag}, 8'h00);
        // Restart counts from zero: timeout lands exactly in cycle 5 again
        for (int k = 0; k < 7; k++) begin
            cyc(5'b10111);
            chk($sformatf("restart_c%0d", k), {3'd0, dev_ready_n}, (k < 5) ? 8'h17 : 8'h1F);
            if (k == 6) chk("restart_flag", {7'd0, tmo_flag}, 8'h01);
        end
        raw_v = 5'b10110;
        cyc(5'b11111, 1'b0, 1'b1);
        cyc(5'b11111);
        chk("restart_clr", {7'd0, tmo_flag}, 8'h00);

        // Timeout on slot 0 coincident with tmo_clr: set wins
        for (int k = 0; k < 7; k++) begin
            cyc(5'b11110, 1'b0, (k == 5));
            chk($sformatf("tmoclr_c%0d", k), {3'd0, dev_ready_n}, (k < 5) ? 8'h1E : 8'h1F);
            if (k == 6) begin
                chk("tmoclr_flag", {7'd0, tmo_flag}, 8'h01);
                chk("tmoclr_slot", {5'd0, tmo_slot}, 8'h00);
            end
        end

        // Reset in WAIT on slot 2 (wait 3), cs_n kept low across release
        raw_v = 5'b11111;
        cyc(5'b11111);
        cyc(5'b11011);
        chk("rstw_c0", {3'd0, dev_ready_n}, 8'h1B);
        cyc(5'b11011);
        chk("rstw_c1", {3'd0, dev_ready_n}, 8'h1B);
        cyc(5'b11011, 1'b1);
        chk("rstw_r0", {3'd0, dev_ready_n}, 8'h1F);
        cyc(5'b11011, 1'b1);
        chk("rstw_r1", {3'd0, dev_ready_n}, 8'h1F);
        chk("rstw_flag", {7'd0, tmo_flag}, 8'h00);
        chk("rstw_slot", {5'd0, tmo_slot}, 8'h00);
        // After release the wait config is back to 0, so cycle 0 is ready at once
        cyc(5'b11011);
        chk("rstw_rel_c0", {3'd0, dev_ready_n}, 8'h1F);
        cyc(5'b11011);
        chk("rstw_rel_c1", {3'd0, dev_ready_n}, 8'h1F);
        cyc(5'b11111);

        // Slot 4 with wait 2; a write during WAIT must not affect this transaction
        cycw(5'b11111, 8'h24, 8'h02);
        cyc(5'b01111);
        chk("s4_c0", {3'd0, dev_ready_n}, 8'h0F);
        cycw(5'b01111, 8'h24, 8'h0F);
        chk("s4_c1", {3'd0, dev_ready_n}, 8'h0F);
        cyc(5'b01111);
        chk("s4_c2", {3'd0, dev_ready_n}, 8'h1F);
        cyc(5'b11111);
        // The new wait of 15 now applies: still stretched at cycle 2
        for (int k = 0; k < 3; k++) begin
            cyc(5'b01111);
            chk($sformatf("s4new_c%0d", k), {3'd0, dev_ready_n}, 8'h0F);
        end
        cyc(5'b11111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slot_ready_ctrl.md
SLOT_READY_CTRL -- requirements
Module: slot_ready_ctrl

Interface
REQ-001 SHALL have parameters: NUM_SLOTS, default 5, number of slot chip selects; WAIT_W, default 4, per-slot min-wait width; TMO_W, default 8, timeout counter width.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cs_n  in  NUM_SLOTS  active-low slot selects from the address decoder.
- slot_ready_n_raw  in  NUM_SLOTS  asynchronous backplane ready per slot; 1 = ready, 0 = wait.
- cfg_we  in  1  config write strobe, sampled on clk.
- cfg_addr  in  8  config register address.
- cfg_wdata  in  8  config write data.
- tmo_clr  in  1  clears tmo_flag.
- dev_ready_n  out  NUM_SLOTS  conditioned ready to the decoder; 1 = ready, 0 = wait.
- tmo_flag  out  1  sticky timeout indicator.
- tmo_slot  out  3  slot of the most recent timeout.

Function
REQ-004 SHALL pass slot_ready_n_raw through a 2-flop synchronizer per bit (sync_rdy), giving 2-cycle latency.
REQ-005 SHALL decode config writes as follows; all other addresses are ignored.
- 0x20+i (i < NUM_SLOTS): wait_i <= cfg_wdata[WAIT_W-1:0].
- 0x28: tmo_lim <= cfg_wdata.
REQ-006 SHALL service one slot at a time: sel = lowest index with cs_n low; all non-selected bits of dev_ready_n are 1.
REQ-007 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-008 SHALL define cycle 0 as the first cycle in IDLE with any cs_n low. At cycle 0 the FSM captures sel, wait_i and tmo_lim, clears elapsed e to 0, and moves to WAIT, or to DONE when REQ-010 yields 1 in cycle 0.
REQ-009 SHALL increment e once per WAIT cycle, saturating at 2^TMO_W-1.
REQ-010 SHALL compute dev_ready_n[sel] in cycle 0 and in WAIT as: 0 when (e < wait_i OR sync_rdy[sel]==0), else 1. In cycle 0 this path is combinational from cs_n, so a stretch is seen in the first cycle.
REQ-011 SHALL time out when tmo_lim != 0, e == tmo_lim, and REQ-010 yields 0: dev_ready_n[sel] is forced to 1 in that cycle, tmo_flag <= 1 and tmo_slot <= sel at the next edge, and the FSM goes to DONE. A timeout overrides wait_i when tmo_lim < wait_i.
REQ-012 SHALL go WAIT->DONE in the first cycle in which dev_ready_n[sel] is 1. In DONE, dev_ready_n[sel] is held at 1 even if the device drops ready.
REQ-013 SHALL go to IDLE from WAIT or DONE when cs_n[sel] is 1; an abort in WAIT does not set tmo_flag. A new cycle 0 requires IDLE.
REQ-014 SHALL apply config writes made during WAIT or DONE only from the next cycle 0.
REQ-015 SHALL keep tmo_flag sticky until a tmo_clr cycle; when a timeout and tmo_clr occur in the same cycle, set wins.
REQ-016 SHALL keep tmo_slot at its last timeout value; tmo_clr does not change it.

Reset
REQ-017 While rst is 1, SHALL force dev_ready_n to all 1s regardless of cs_n.
REQ-018 At the edge where rst is 1, SHALL load: state=IDLE, e=0, wait_i=0, tmo_lim=8'h40, sync flops=1, tmo_flag=0, tmo_slot=0.
REQ-019 SHALL treat a cs_n already low at reset release as a new cycle 0 in the first cycle after release.

Verification
REQ-020 Reset/no-wait: release rst; cs_n=5'b11101, raw all 1, wait=0 -> dev_ready_n=5'b11111 in every cycle; tmo_flag=0, tmo_slot=0.
REQ-021 Min wait: write 0x22=0x03; cs_n[2] low 6 cycles, raw all 1 -> dev_ready_n[2]=0 in cycles 0-2 and 1 in cycles 3-5; other bits 1.
REQ-022 Device stall: raw[1]=0, raised during cycle 4, cs_n[1] low -> dev_ready_n[1]=0 in cycles 0-5 and 1 from cycle 6; no timeout.
REQ-023 Timeout: write 0x28=0x05; raw[3] held 0, cs_n[3] low -> dev_ready_n[3]=0 in cycles 0-4 and 1 from cycle 5; tmo_flag=1, tmo_slot=3 from cycle 6; tmo_clr pulse -> tmo_flag=0, tmo_slot stays 3.
REQ-024 Abort and priority: cs_n=5'b00111 with slot 3 stalled -> only bit 3 is driven 0; cs_n deasserted in cycle 2 -> IDLE, tmo_flag stays 0. The next assertion restarts counting at e=0.
REQ-025 Corner cases: timeout coincident with a tmo_clr pulse -> tmo_flag=1. rst asserted in WAIT -> dev_ready_n=5'b11111 while rst=1; the cycle restarts at cycle 0 after release if cs_n is still low.
